// File: rtl/da_fir_engine.sv
// Distributed-arithmetic MAC engine: NBANK coefficient-sum LUTs, one
// bit-slice accumulated per cycle (LSB first) over XW cycles, with a
// per-run signed/unsigned select and a busy/valid handshake.
module da_fir_engine #(
   parameter int NBANK = 8,
   parameter int ABITS = 8,
   parameter int CW    = 20,
   parameter int XW    = 16,
   localparam int BSEL = $clog2(NBANK),
   localparam int ACCW = CW + XW + $clog2(NBANK)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cload,
   input  logic [BSEL+ABITS-1:0]    caddr,
   input  logic [CW-1:0]            cin,
   input  logic                     start,
   input  logic                     tc_mode,
   input  logic [NBANK*ABITS-1:0]   addr_in,
   output logic                     busy,
   output logic [ACCW-1:0]          acc_out,
   output logic                     valid_out,
   output logic                     load_err
);

   localparam int CNTW = (XW > 1) ? $clog2(XW) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                  state, state_nxt;
   logic [CNTW-1:0]         cnt, rd_k;
   logic                    rd_vld, tc_q;
   logic signed [CW-1:0]    lut [NBANK][2**ABITS];
   logic signed [CW-1:0]    rd_word [NBANK];
   logic signed [ACCW-1:0]  acc, sum, term, acc_nxt;
   logic [BSEL-1:0]         wr_bank;
   logic [ABITS-1:0]        wr_word;
   logic                    wr_en, last_k;

   assign wr_bank = caddr[ABITS +: BSEL];
   assign wr_word = caddr[ABITS-1:0];
   // Out-of-range bank fields are silently dropped.
   assign wr_en   = cload && (state == IDLE) &&
                    ({1'b0, wr_bank} < (BSEL+1)'(NBANK));
   assign last_k  = (rd_k == CNTW'(XW-1));

   // LUT storage: written only in IDLE, never reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         lut[wr_bank][wr_word] <= cin;
   end

   // Registered LUT read of the current bit-slice address for every bank.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < NBANK; b++)
         rd_word[b] <= lut[b][addr_in[b*ABITS +: ABITS]];
   end

   // Sum bank outputs, weight by slice position; the MSB slice subtracts in signed mode.
   always_comb begin
      sum = '0;
      for (int unsigned b = 0; b < NBANK; b++)
         sum = sum + ACCW'(rd_word[b]);
      term    = sum <<< rd_k;
      acc_nxt = (tc_q && last_k) ? acc - term : acc + term;
   end

   // State, slice counter, read-pipeline tags, accumulator and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rd_k     <= '0;
         rd_vld   <= 1'b0;
         tc_q     <= 1'b0;
         acc      <= '0;
         acc_out  <= '0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         load_err <= cload && (state != IDLE);
         rd_vld   <= (state == RUN);
         rd_k     <= cnt;
         if (state == IDLE && start) begin
            acc  <= '0;
            cnt  <= '0;
            tc_q <= tc_mode;
         end else begin
            if (state == RUN)
               cnt <= cnt + 1'b1;
            if (rd_vld)
               acc <= acc_nxt;
         end
         // Result is published on the same edge the last slice is folded in.
         if (rd_vld && last_k)
            acc_out <= acc_nxt;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      valid_out = (state == DONE);
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == CNTW'(XW-1)) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
